// File: rtl/regbank_arb_pkg.sv
// Shared types for the register-bank write-port arbiter: register geometry,
// arbiter FSM states and the buffered write entry.
package regbank_arb_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              high;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/regbank_wb_fifo.sv
// ALU write buffer: DEPTH-entry circular FIFO with synchronous flush.
// reset is asynchronous active-low; a push while full is taken only alongside a pop.
module regbank_wb_fifo
  import regbank_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] din_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               last_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign last_o  = (count_q == CNT_W'(1));
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers are PTR_W wide with DEPTH a power of two, so they wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates the register bank write port between load returns (always win) and buffered ALU
// results, scoreboards in-flight destinations for decode hazards. Optional REGARB_BYPASS_EN.
module regbank_wb_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [31:0]       alu_data,
  input  logic              alu_high,
  input  logic              ld_issue,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [31:0]       byp_data_a,
  output logic [31:0]       byp_data_b,
  output logic              wb_we,
  output logic              wb_high,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 2);

  arb_state_e         state_q;
  logic [NUM_REGS-1:0] ld_pend_q, ld_pend_d;
  logic [CNT_W-1:0]   alu_cnt_q [NUM_REGS];
  logic [CNT_W-1:0]   alu_cnt_d [NUM_REGS];
  wb_entry_t          wb_q, wb_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_mem_q, wb_mem_d;

  logic               alu_acc, alu_nz, direct;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_last;
  logic [ENTRY_W-1:0] fifo_head_raw;
  wb_entry_t          fifo_head, alu_entry;
  logic [ADDR_W-1:0]  rd [2];
  logic [1:0]         hz;
  logic [31:0]        byp [2];

  assign alu_ready = !fifo_full && (state_q != FLUSH);
  assign alu_acc   = alu_valid && alu_ready && !flush;
  assign alu_nz    = (alu_addr != '0);
  assign fifo_pop  = !mem_valid && !flush && !fifo_empty;
  // An empty buffer with a free port forwards the ALU write straight to wb_*.
  assign direct    = !mem_valid && fifo_empty && alu_acc && alu_nz;
  assign fifo_push = alu_acc && alu_nz && !direct;
  assign alu_entry = '{addr: alu_addr, data: alu_data, high: alu_high};
  assign fifo_head = wb_entry_t'(fifo_head_raw);
  assign ld_ready  = !ld_pend_q[ld_addr];

  regbank_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .din_i   (alu_entry),
    .head_o  (fifo_head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  always_comb begin
    wb_we_d  = 1'b0;
    wb_mem_d = 1'b0;
    wb_d     = wb_q;
    if (mem_valid) begin
      if (mem_addr != '0) begin
        wb_we_d  = 1'b1;
        wb_mem_d = 1'b1;
        wb_d     = '{addr: mem_addr, data: mem_data, high: 1'b0};
      end
    end else if (fifo_pop) begin
      wb_we_d = 1'b1;
      wb_d    = fifo_head;
    end else if (direct) begin
      wb_we_d = 1'b1;
      wb_d    = alu_entry;
    end
  end

  // Scoreboard entries retire when their write is the one currently on wb_*.
  always_comb begin
    ld_pend_d = ld_pend_q;
    if (wb_we_q && wb_mem_q) ld_pend_d[wb_q.addr] = 1'b0;
    if (ld_issue && ld_ready && (ld_addr != '0)) ld_pend_d[ld_addr] = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      alu_cnt_d[r] = '0;
      if (!flush) begin
        alu_cnt_d[r] = alu_cnt_q[r]
                     + CNT_W'(alu_acc && alu_nz && (alu_addr == ADDR_W'(r)))
                     - CNT_W'(wb_we_q && !wb_mem_q && (wb_q.addr == ADDR_W'(r)));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we_q   <= 1'b0;
      wb_mem_q  <= 1'b0;
      wb_q      <= '0;
      ld_pend_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) alu_cnt_q[r] <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_mem_q  <= wb_mem_d;
      wb_q      <= wb_d;
      ld_pend_q <= ld_pend_d;
      for (int r = 0; r < NUM_REGS; r++) alu_cnt_q[r] <= alu_cnt_d[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (fifo_push) state_q <= DRAIN;
        DRAIN:   if (fifo_pop && fifo_last && !fifo_push) state_q <= IDLE;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd[0] = rd_addr_a;
  assign rd[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hz[p]  = (rd[p] != '0) && (ld_pend_q[rd[p]] || (alu_cnt_q[rd[p]] != '0));
      byp[p] = '0;
`ifdef REGARB_BYPASS_EN
      // Forward only when the write on wb_* leaves nothing else outstanding for rd.
      if (wb_we_q && (rd[p] != '0) && (wb_q.addr == rd[p]) &&
          !((ld_pend_q[rd[p]] && !wb_mem_q) || (alu_cnt_q[rd[p]] != CNT_W'(!wb_mem_q)))) begin
        hz[p]  = wb_q.high;
        byp[p] = wb_q.high ? {wb_q.data[15:0], 16'h0} : wb_q.data;
      end
`endif
    end
  end

  assign hazard_a   = hz[0];
  assign hazard_b   = hz[1];
  assign byp_data_a = byp[0];
  assign byp_data_b = byp[1];
  assign wb_we      = wb_we_q;
  assign wb_high    = wb_q.high;
  assign wb_addr    = wb_q.addr;
  assign wb_data    = wb_q.data;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomised and directed checks of regbank_wb_arbiter against a queue-based reference model.
module tb_regbank_wb_arbiter;

  localparam int DEPTH = 2;
`ifdef REGARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, alu_high;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_issue, ld_ready;
  logic [3:0]  ld_addr;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data;
  logic        flush;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        hazard_a, hazard_b;
  logic [31:0] byp_data_a, byp_data_b;
  logic        wb_we, wb_high;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  regbank_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_high(alu_high),
    .ld_issue(ld_issue), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .flush(flush), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .byp_data_a(byp_data_a), .byp_data_b(byp_data_b),
    .wb_we(wb_we), .wb_high(wb_high), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        high;
  } wr_t;

  // Reference model: pending ALU writes as an ordered queue, the write on the port, load flags.
  wr_t         q[$];
  logic [15:0] pend;
  logic        m_we, m_mem, m_high, m_flush, m_acc;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int qcount(input logic [3:0] r);
    int n = 0;
    foreach (q[i]) if (q[i].addr == r) n++;
    return n;
  endfunction

  function automatic logic m_ready();
    return (q.size() < DEPTH) && !m_flush;
  endfunction

  task automatic exp_read(input logic [3:0] rd, output logic hz, output logic [31:0] byp);
    hz  = (rd != 0) && (pend[rd] || (qcount(rd) > 0) || (m_we && !m_mem && m_addr == rd));
    byp = 32'h0;
    if (BYP && m_we && rd != 0 && m_addr == rd && !((pend[rd] && !m_mem) || (qcount(rd) > 0))) begin
      hz  = m_high;
      byp = m_high ? {m_data[15:0], 16'h0} : m_data;
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = '0; m_we = 0; m_mem = 0; m_high = 0; m_flush = 0; m_acc = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_tick();
    logic direct, lr;
    wr_t  w;
    m_acc  = alu_valid && m_ready() && !flush;
    lr     = !pend[ld_addr];
    if (m_we && m_mem) pend[m_addr] = 1'b0;
    if (ld_issue && lr && ld_addr != 0) pend[ld_addr] = 1'b1;
    direct = 1'b0;
    m_we   = 1'b0;
    if (mem_valid) begin
      if (mem_addr != 0) begin
        m_we = 1; m_mem = 1; m_addr = mem_addr; m_data = mem_data; m_high = 0;
      end
    end else if (!flush && q.size() > 0) begin
      w = q.pop_front();
      m_we = 1; m_mem = 0; m_addr = w.addr; m_data = w.data; m_high = w.high;
    end else if (m_acc && alu_addr != 0) begin
      direct = 1;
      m_we = 1; m_mem = 0; m_addr = alu_addr; m_data = alu_data; m_high = alu_high;
    end
    if (flush) q.delete();
    else if (m_acc && alu_addr != 0 && !direct) begin
      w.addr = alu_addr; w.data = alu_data; w.high = alu_high;
      q.push_back(w);
    end
    m_flush = flush;
  endtask

  task automatic check_outputs();
    logic hz;
    logic [31:0] byp;
    chk("alu_ready", alu_ready, m_ready());
    chk("ld_ready", ld_ready, !pend[ld_addr]);
    exp_read(rd_addr_a, hz, byp);
    chk("hazard_a", hazard_a, hz);
    chk("byp_data_a", byp_data_a, byp);
    exp_read(rd_addr_b, hz, byp);
    chk("hazard_b", hazard_b, hz);
    chk("byp_data_b", byp_data_b, byp);
    chk("wb_we", wb_we, m_we);
    if (m_we) begin
      chk("wb_addr", wb_addr, m_addr);
      chk("wb_data", wb_data, m_data);
      chk("wb_high", wb_high, m_high);
    end
  endtask

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; alu_high = 0; ld_issue = 0; mem_valid = 0; flush = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_wb_high"}, wb_high, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_alu_ready"}, alu_ready, 1);
    chk({tag, "_ld_ready"}, ld_ready, 1);
    chk({tag, "_hazard_a"}, hazard_a, 0);
    chk({tag, "_hazard_b"}, hazard_b, 0);
    chk({tag, "_byp_a"}, byp_data_a, 0);
    chk({tag, "_byp_b"}, byp_data_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, acc_mem;
    n_chk = 0; n_fail = 0;
    idle();
    alu_addr = 0; alu_data = 0; ld_addr = 0; mem_addr = 0; mem_data = 0;
    rd_addr_a = 3; rd_addr_b = 5;
    reset = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset = 1;

    // Single ALU write to an idle port.
    alu_valid = 1; alu_addr = 3; alu_data = 32'h1234_5678;
    step(); idle();
    #1;
    chk("t1_we", wb_we, 1);
    chk("t1_addr", wb_addr, 3);
    chk("t1_hz", hazard_a, BYP ? 32'd0 : 32'd1);
    step();
    #1 chk("t1_hz_clear", hazard_a, 0);
    step();

    // Load return and ALU push collide: load first.
    rd_addr_a = 5;
    alu_valid = 1; alu_addr = 5; alu_data = 32'h0000_0055;
    mem_valid = 1; mem_addr = 7; mem_data = 32'hDEAD_BEEF;
    step(); idle();
    #1; chk("t2_first_addr", wb_addr, 7); chk("t2_first_data", wb_data, 32'hDEAD_BEEF);
    step();
    #1; chk("t2_second_we", wb_we, 1); chk("t2_second_addr", wb_addr, 5);
    step();
    #1 chk("t2_cnt_zero", hazard_a, 0);
    step();

    // Eight back-to-back pushes while loads own the port.
    idx = 0; acc_mem = 0;
    for (int c = 0; c < 30; c++) begin
      mem_valid = (c < 6); mem_addr = 10; mem_data = 32'hA000_0000 + c;
      alu_valid = (idx < 8); alu_addr = 4'(1 + idx); alu_data = 32'h1000_0000 + idx;
      if (c == 3) begin #1 chk("t3_full", alu_ready, 0); end
      step();
      if (m_acc) idx++;
      if (c == 5) acc_mem = idx;
    end
    idle();
    chk("t3_acc_while_mem", acc_mem, 2);
    chk("t3_all_accepted", idx, 8);
    repeat (2) step();

    // Duplicate load to a pending register is refused.
    rd_addr_a = 4; ld_addr = 4; ld_issue = 1;
    step();
    #1; chk("t4_ld_blocked", ld_ready, 0); chk("t4_hz", hazard_a, 1);
    step(); ld_issue = 0;
    repeat (3) step();
    mem_valid = 1; mem_addr = 4; mem_data = 32'h0000_0044;
    step(); idle();
    #1;
    chk("t4_ld_present", ld_ready, 0);
    chk("t4_hz_present", hazard_a, BYP ? 32'd0 : 32'd1);
    chk("t4_byp_present", byp_data_a, BYP ? 32'h44 : 32'h0);
    step();
    #1; chk("t4_ld_free", ld_ready, 1); chk("t4_hz_clear", hazard_a, 0);
    step();

    // Flush discards buffered ALU writes but not an outstanding load.
    ld_addr = 9; ld_issue = 1;
    step(); ld_issue = 0;
    mem_valid = 1; mem_addr = 10; mem_data = 32'hBBBB_0000;
    alu_valid = 1; alu_addr = 2; alu_data = 32'h2222_2222;
    step();
    alu_addr = 6; alu_data = 32'h6666_6666;
    step(); idle();
    rd_addr_a = 2; rd_addr_b = 9; flush = 1;
    step(); idle();
    #1;
    chk("t5_ready_low", alu_ready, 0);
    chk("t5_hz_r2", hazard_a, 0);
    chk("t5_hz_r9", hazard_b, 1);
    chk("t5_ld9_pend", ld_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      #1 chk("t5_no_write", wb_we, 0);
    end
    mem_valid = 1; mem_addr = 9; mem_data = 32'h9999_9999;
    step(); idle();
    step();

    // Bypass of a full-word and a high-half write.
    rd_addr_a = 3;
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA5A5_A5A5;
    step(); idle();
    #1; chk("t6_hz", hazard_a, BYP ? 32'd0 : 32'd1); chk("t6_byp", byp_data_a, BYP ? 32'hA5A5_A5A5 : 32'h0);
    step();
    alu_valid = 1; alu_addr = 3; alu_data = 32'h0000_1234; alu_high = 1;
    step(); idle();
    #1; chk("t6_hi_hz", hazard_a, 1); chk("t6_hi_byp", byp_data_a, BYP ? 32'h1234_0000 : 32'h0);
    step();

    // Writes to r0 are accepted and dropped.
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF_FFFF;
    step(); idle();
    #1 chk("t7_r0_drop", wb_we, 0);
    step();

    // Asynchronous reset while the buffer drains.
    mem_valid = 1; mem_addr = 13; alu_valid = 1; alu_addr = 11; alu_data = 32'h1111_1111;
    step();
    alu_addr = 12; alu_data = 32'h1212_1212;
    step(); idle();
    step();
    #1 chk("t8_pre_we", wb_we, 1);
    reset = 0;
    #1 check_reset_vals("arst");
    model_reset();
    @(negedge clk);
    reset = 1;

    // Random traffic with narrow address ranges to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom_range(1, 0) == 1);
      alu_addr  = 4'($urandom_range(5, 0));
      alu_data  = $urandom;
      alu_high  = ($urandom_range(4, 0) == 0);
      ld_issue  = ($urandom_range(2, 0) == 0);
      ld_addr   = 4'($urandom_range(6, 0));
      mem_valid = ($urandom_range(3, 0) == 0);
      mem_addr  = 4'($urandom_range(6, 0));
      mem_data  = $urandom;
      flush     = ($urandom_range(39, 0) == 0);
      rd_addr_a = 4'($urandom_range(6, 0));
      rd_addr_b = 4'($urandom_range(6, 0));
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
